// File: rtl/four_to_two_encoder_q.sv
// Queued 4:2 priority encoder: multi-hot requests are latched into a pending
// vector and emitted one index at a time over a valid/ready handshake.
module four_to_two_encoder_q (
  input  logic       clk,
  input  logic       rst,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic       ready,
  output logic       a,
  output logic       b,
  output logic       valid,
  output logic       busy,
  output logic [3:0] drop_cnt
);

  localparam int unsigned REQ_W   = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state, state_next;
  logic [REQ_W-1:0]   req, pending, pending_next, pop_mask, drop_mask;
  logic [IDX_W-1:0]   sel, code_next;
  logic               load;
  logic [2:0]         drop_num;
  logic [CNT_W:0]     drop_sum;
  logic [CNT_W-1:0]   drop_cnt_next;
  logic               valid_next, busy_next;

  assign req = {d3, d2, d1, d0};

  // Next-state, pop selection and drop accounting
  always_comb begin
    state_next    = state;
    code_next     = {a, b};
    load          = 1'b0;
    pop_mask      = '0;
    sel           = IDX_W'(0);

    // Highest pending index wins; only the registered pending vector is used
    if (pending[3])      sel = IDX_W'(3);
    else if (pending[2]) sel = IDX_W'(2);
    else if (pending[1]) sel = IDX_W'(1);

    case (state)
      IDLE: begin
        if (pending != '0) begin
          load       = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (ready) begin
          if (pending != '0) load = 1'b1;
          else               state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (load) begin
      pop_mask  = REQ_W'(1) << sel;
      code_next = sel;
    end

    pending_next = (pending & ~pop_mask) | req;

    // A request onto a still-pending, un-popped bit is lost
    drop_mask = req & pending & ~pop_mask;
    drop_num  = 3'(drop_mask[0]) + 3'(drop_mask[1]) + 3'(drop_mask[2]) + 3'(drop_mask[3]);
    drop_sum  = (CNT_W+1)'(drop_cnt) + (CNT_W+1)'(drop_num);
    drop_cnt_next = (drop_sum > (CNT_W+1)'(CNT_MAX)) ? CNT_W'(CNT_MAX) : drop_sum[CNT_W-1:0];

    valid_next = (state_next == SEND);
    busy_next  = (pending_next != '0) || valid_next;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      a        <= 1'b0;
      b        <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state    <= state_next;
      pending  <= pending_next;
      a        <= code_next[1];
      b        <= code_next[0];
      valid    <= valid_next;
      busy     <= busy_next;
      drop_cnt <= drop_cnt_next;
    end
  end

endmodule

// File: tb/tb_four_to_two_encoder_q.sv
// Directed self-checking bench for four_to_two_encoder_q.
module tb_four_to_two_encoder_q;

  logic       clk = 1'b0;
  logic       rst, d0, d1, d2, d3, ready;
  logic       a, b, valid, busy;
  logic [3:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  four_to_two_encoder_q dut (
    .clk      (clk),
    .rst      (rst),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .ready    (ready),
    .a        (a),
    .b        (b),
    .valid    (valid),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] r);
    {d3, d2, d1, d0} = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(4'b0000);
    step();
    rst = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [1:0] code);
    check_eq({tag, "_valid"}, 8'(valid), 8'(v));
    if (v) check_eq({tag, "_code"}, 8'({a, b}), 8'(code));
  endtask

  initial begin
    logic [1:0] order [4];
    order[0] = 2'd3; order[1] = 2'd2; order[2] = 2'd1; order[3] = 2'd0;
    rst = 1'b1; ready = 1'b0; set_req(4'b0000);

    // Reset state
    do_reset();
    check_eq("rst_valid", 8'(valid), 8'd0);
    check_eq("rst_ab", 8'({a, b}), 8'd0);
    check_eq("rst_busy", 8'(busy), 8'd0);
    check_eq("rst_drop", 8'(drop_cnt), 8'd0);

    // Single request on d2, two-cycle latency
    ready = 1'b1;
    set_req(4'b0100);
    step();
    set_req(4'b0000);
    check_eq("single_lat1_valid", 8'(valid), 8'd0);
    check_eq("single_lat1_busy", 8'(busy), 8'd1);
    step();
    expect_out("single_out", 1'b1, 2'd2);
    step();
    expect_out("single_after", 1'b0, 2'd0);
    check_eq("single_busy_end", 8'(busy), 8'd0);

    // All four at once: emitted highest index first, back-to-back
    do_reset();
    ready = 1'b1;
    set_req(4'b1111);
    step();
    set_req(4'b0000);
    check_eq("multi_lat_valid", 8'(valid), 8'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out($sformatf("multi_%0d", i), 1'b1, order[i]);
    end
    step();
    expect_out("multi_end", 1'b0, 2'd0);
    check_eq("multi_drop", 8'(drop_cnt), 8'd0);
    check_eq("multi_busy", 8'(busy), 8'd0);

    // Backpressure holds the code stable
    do_reset();
    ready = 1'b0;
    set_req(4'b0010);
    step();
    set_req(4'b0000);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out($sformatf("bp_hold_%0d", i), 1'b1, 2'd1);
    end
    ready = 1'b1;
    step();
    expect_out("bp_accept", 1'b0, 2'd0);
    step();
    expect_out("bp_idle", 1'b0, 2'd0);
    check_eq("bp_busy", 8'(busy), 8'd0);

    // Held d0 with ready low: drops count up and saturate at 15
    do_reset();
    ready = 1'b0;
    set_req(4'b0001);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 2)  check_eq("drop_k2", 8'(drop_cnt), 8'd0);
      if (k == 5)  check_eq("drop_k5", 8'(drop_cnt), 8'd3);
      if (k == 17) check_eq("drop_k17", 8'(drop_cnt), 8'd15);
      if (k == 20) check_eq("drop_k20", 8'(drop_cnt), 8'd15);
    end
    set_req(4'b0000);
    step();
    expect_out("drop_held", 1'b1, 2'd0);
    ready = 1'b1;
    step();
    expect_out("drop_second", 1'b1, 2'd0);
    step();
    expect_out("drop_drained", 1'b0, 2'd0);
    check_eq("drop_busy", 8'(busy), 8'd0);
    check_eq("drop_final", 8'(drop_cnt), 8'd15);

    // Re-request d3 in the cycle it is popped: emitted twice, no drop
    do_reset();
    ready = 1'b1;
    set_req(4'b1000);
    step();
    step();
    set_req(4'b0000);
    expect_out("coll_first", 1'b1, 2'd3);
    step();
    expect_out("coll_second", 1'b1, 2'd3);
    step();
    expect_out("coll_end", 1'b0, 2'd0);
    check_eq("coll_drop", 8'(drop_cnt), 8'd0);

    // Reset mid-stream, with live requests on the reset cycle
    do_reset();
    ready = 1'b0;
    set_req(4'b1111);
    step();
    set_req(4'b0000);
    step();
    expect_out("mrst_pre", 1'b1, 2'd3);
    rst = 1'b1;
    set_req(4'b1111);
    step();
    rst = 1'b0;
    set_req(4'b0000);
    ready = 1'b1;
    check_eq("mrst_valid", 8'(valid), 8'd0);
    check_eq("mrst_busy", 8'(busy), 8'd0);
    check_eq("mrst_drop", 8'(drop_cnt), 8'd0);
    check_eq("mrst_ab", 8'({a, b}), 8'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("mrst_quiet_%0d", i), 8'(valid), 8'd0);
    end
    check_eq("mrst_busy_end", 8'(busy), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/four_to_two_encoder_q.md
FOUR_TO_TWO_ENCODER_Q -- requirements
Module: four_to_two_encoder_q

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  The single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  Reset, synchronous and active-high.
REQ-004 d0  input  1  Request line for index 0 (code a=0, b=0).
REQ-005 d1  input  1  Request line for index 1 (code a=0, b=1).
REQ-006 d2  input  1  Request line for index 2 (code a=1, b=0).
REQ-007 d3  input  1  Request line for index 3 (code a=1, b=1).
REQ-008 a  output  1  Encoded index MSB, registered.
REQ-009 b  output  1  Encoded index LSB, registered.
REQ-010 valid  output  1  {a,b} holds an encoded request, registered.
REQ-011 ready  input  1  Consumer accepts {a,b} in any cycle where valid=1 and ready=1.
REQ-012 busy  output  1  Registered; equals (pending != 0) or valid.
REQ-013 drop_cnt  output  4  Saturating count of dropped requests, registered.

Function
REQ-014 Input lines SHALL be treated as multi-hot; every high line in a cycle is a separate request.
REQ-015 A 4-bit pending register SHALL hold requests that have been captured but not yet emitted.
REQ-016 Next-state update: pending_next = (pending & ~pop_mask) | {d3,d2,d1,d0}.
  - pop_mask is the one-hot bit moved to the output register in this cycle, or 0 if none.
REQ-017 Output selection SHALL use the registered pending value only, never the same-cycle inputs.
REQ-018 Output selection SHALL pick the highest set index first (d3 > d2 > d1 > d0).
REQ-019 Latency: a request on d_i in cycle N, with the output slot free, SHALL give valid=1 and {a,b}=i in cycle N+2.
REQ-020 FSM states: IDLE (valid=0) and SEND (valid=1).
REQ-021 IDLE -> SEND when pending != 0; the selected index is loaded into {a,b} and its bit is popped.
REQ-022 SEND, ready=0: the state SHALL remain SEND, and {a,b} SHALL stay stable with no pop.
REQ-023 SEND, ready=1, pending != 0: the state SHALL remain SEND and the next index SHALL be loaded and popped the same edge.
  - This gives back-to-back output with no bubble.
REQ-024 SEND, ready=1, pending == 0: the state SHALL go to IDLE, with valid=0 from the next cycle.
REQ-025 In IDLE, {a,b} SHALL hold its last value; ready SHALL be ignored when valid=0.
REQ-026 Drop rule: d_i high while pending[i]=1 and pending[i] is not popped this cycle is a dropped request.
  - drop_cnt SHALL increment by the number of dropped bits in that cycle (0-4).
  - drop_cnt SHALL saturate at 15.
REQ-027 d_i high in the same cycle pending[i] is popped SHALL re-set pending[i], with no drop.
REQ-028 d_i high while index i sits in the output register SHALL set pending[i] with no drop, so the index is emitted again later.
REQ-029 Holding d_i high for k cycles with the index not drained SHALL count k-1 drops.

Reset
REQ-030 When rst=1 at a rising edge, the block SHALL set the following, overriding all inputs in that cycle:
  - pending=0, state=IDLE, valid=0
  - a=0, b=0, busy=0, drop_cnt=0
REQ-031 Reset asserted during SEND SHALL discard the held output and all pending requests; valid=0 in the cycle after the reset edge.
REQ-032 Requests present in the cycle rst=1 SHALL NOT be captured.

Verification
REQ-033 Single request: rst then release; d2=1 for one cycle, ready=1 -> valid=1 with {a,b}=10 exactly 2 cycles later, for 1 cycle; busy returns to 0.
REQ-034 Multi-hot with priority: d0..d3=1111 for one cycle, ready=1 -> output order 11, 10, 01, 00 on consecutive cycles, valid held 4 cycles, drop_cnt=0.
REQ-035 Backpressure: d1=1 with ready=0 for 5 cycles after valid -> {a,b}=01 stable all 5 cycles; ready=1 -> single accept, then valid=0.
REQ-036 Drop and saturate: ready=0, d0 held high for 20 cycles -> drop_cnt counts up and stays at 15; after release and drain, exactly the code 00 is emitted.
REQ-037 Pop collision: with pending={d3}, assert d3 in the cycle it is popped -> 11 is emitted twice, drop_cnt unchanged.
REQ-038 Mid-operation reset: 3 pending requests and valid=1, then rst=1 for 1 cycle -> next cycle valid=0, busy=0, drop_cnt=0, and no further output.
